vending_fsm_param: RTL and testbench

Parametrised vending-machine controller, the next generation of the team's fixed two-beverage `Fsm`. It accumulates coin credit and accepts product selections against a configurable price table. It delivers the product for a programmable number of cycles, then returns change. Compared with `Fsm` it adds a credit cap, an explicit cancel/refund, error reporting and a credit readback. It sits between the coin acceptor and button panel on one side and the dispenser and change hopper on the other.

---
 rtl/vending_pkg.sv | 32 +++
 rtl/vend_delay_cnt.sv | 27 ++
 rtl/vending_fsm_param.sv | 161 ++++++++++++++++
 tb/tb_vending_fsm_param.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the parametrised vending controller.
// Holds the state encoding, the default price table and the minimum-price helper.
package vending_pkg;

  typedef enum logic [1:0] {
    VEND_IDLE    = 2'd0,
    VEND_DELIVER = 2'd1,
    VEND_CHANGE  = 2'd2
  } vend_state_e;

  // Price tables are passed flattened as 32-bit entries so the helper works for any BTN_W up to 4.
  localparam int unsigned VEND_MAX_CODES = 16;

  localparam int unsigned VEND_DEFAULT_PRICES [4] = '{0, 30, 0, 50};

  function automatic int unsigned vend_min_price(
    input logic [VEND_MAX_CODES*32-1:0] prices_flat,
    input int unsigned                  n_codes
  );
    int unsigned m;
    int unsigned p;
    m = 0;
    for (int unsigned i = 0; i < VEND_MAX_CODES; i++) begin
      if (i < n_codes) begin
        p = prices_flat[i*32 +: 32];
        if (p != 0 && (m == 0 || p < m)) m = p;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/vend_delay_cnt.sv
// Loadable down-counter with a terminal-count flag, shared by the DELIVER and CHANGE phases.
// Loading N-1 makes tc rise in the N-th cycle after the load edge.
module vend_delay_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: coin credit with ceiling, priced selections, timed delivery and change.
// Define VEND_AUTOCHANGE_EN to refund leftover credit below the cheapest price automatically after delivery.
module vending_fsm_param
  import vending_pkg::*;
#(
  parameter int          CREDIT_W    = 16,
  parameter int          BTN_W       = 2,
  parameter int unsigned PRICES [2**BTN_W] = VEND_DEFAULT_PRICES,
  parameter int          DELIVER_CYC = 10,
  parameter int          CHANGE_CYC  = 20,
  parameter int          CREDIT_MAX  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CREDIT_W-1:0] coin_in,
  input  logic [BTN_W-1:0]    button_in,
  input  logic                cancel_in,
  output logic [BTN_W-1:0]    beverage_out,
  output logic [CREDIT_W-1:0] change_out,
  output logic [CREDIT_W-1:0] credit_out,
  output logic                busy_out,
  output logic                error_out
);

  localparam logic [1:0] ST_IDLE    = 2'(VEND_IDLE);
  localparam logic [1:0] ST_DELIVER = 2'(VEND_DELIVER);
  localparam logic [1:0] ST_CHANGE  = 2'(VEND_CHANGE);

  localparam int unsigned N_CODES = 2**BTN_W;

`ifdef VEND_AUTOCHANGE_EN
  localparam bit AUTOCHG_EN = 1'b1;
`else
  localparam bit AUTOCHG_EN = 1'b0;
`endif

  function automatic logic [VEND_MAX_CODES*32-1:0] flatten_prices();
    logic [VEND_MAX_CODES*32-1:0] f;
    f = '0;
    for (int unsigned i = 0; i < N_CODES; i++) f[i*32 +: 32] = PRICES[i];
    return f;
  endfunction

  localparam int unsigned MIN_PRICE = vend_min_price(flatten_prices(), N_CODES);
  localparam logic [CREDIT_W-1:0] MIN_PRICE_W = CREDIT_W'(MIN_PRICE);
  localparam logic [CREDIT_W:0]   CREDIT_CAP  = (CREDIT_W+1)'(CREDIT_MAX);

  localparam int CNT_MAX = (DELIVER_CYC > CHANGE_CYC) ? DELIVER_CYC : CHANGE_CYC;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELIVER_LOAD = CNT_W'(DELIVER_CYC - 1);
  localparam logic [CNT_W-1:0] CHANGE_LOAD  = CNT_W'(CHANGE_CYC - 1);

  logic [1:0]          state, state_nx;
  logic [CREDIT_W-1:0] credit, credit_nx;
  logic [BTN_W-1:0]    bev_nx;
  logic [CREDIT_W-1:0] change_nx;
  logic                err_nx;
  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_val;
  logic                cnt_tc;

  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                coin_rej;
  logic [CREDIT_W-1:0] coin_add;
  logic [CREDIT_W-1:0] price;
  logic                autochg_hit;

  vend_delay_cnt #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  // Cap check is done one bit wider so a large coin can never wrap past the ceiling.
  assign coin_sum    = {1'b0, credit} + {1'b0, coin_in};
  assign coin_ok     = (coin_in != '0) && (coin_sum <= CREDIT_CAP);
  assign coin_rej    = (coin_in != '0) && !coin_ok;
  assign coin_add    = coin_ok ? coin_in : '0;
  assign price       = CREDIT_W'(PRICES[button_in]);
  assign autochg_hit = AUTOCHG_EN && (credit != '0) && (credit < MIN_PRICE_W);

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    bev_nx    = beverage_out;
    change_nx = change_out;
    err_nx    = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      ST_IDLE: begin
        if (cancel_in && credit != '0) begin
          state_nx  = ST_CHANGE;
          change_nx = credit;
          cnt_load  = 1'b1;
          cnt_val   = CHANGE_LOAD;
        end else if (button_in != '0) begin
          if (price != '0 && credit >= price) begin
            credit_nx = credit - price + coin_add;
            err_nx    = coin_rej;
            bev_nx    = button_in;
            state_nx  = ST_DELIVER;
            cnt_load  = 1'b1;
            cnt_val   = DELIVER_LOAD;
          end else begin
            err_nx = 1'b1;
          end
        end else begin
          credit_nx = credit + coin_add;
          err_nx    = coin_rej;
        end
      end
      ST_DELIVER: begin
        if (cnt_tc) begin
          bev_nx = '0;
          if (autochg_hit) begin
            state_nx  = ST_CHANGE;
            change_nx = credit;
            cnt_load  = 1'b1;
            cnt_val   = CHANGE_LOAD;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_CHANGE: begin
        if (cnt_tc) begin
          credit_nx = '0;
          change_nx = '0;
          state_nx  = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      credit       <= '0;
      beverage_out <= '0;
      change_out   <= '0;
      error_out    <= 1'b0;
    end else begin
      state        <= state_nx;
      credit       <= credit_nx;
      beverage_out <= bev_nx;
      change_out   <= change_nx;
      error_out    <= err_nx;
    end
  end

  assign credit_out = credit;
  assign busy_out   = (state != ST_IDLE);

endmodule

// File: tb/tb_vending_fsm_param.sv
// Self-checking bench for vending_fsm_param with a transaction-level credit model.
// Expectations follow VEND_AUTOCHANGE_EN when the bench is built with it.
module tb_vending_fsm_param;

  localparam int CW   = 16;
  localparam int BW   = 2;
  localparam int D    = 10;
  localparam int C    = 20;
  localparam int CMAX = 1000;

`ifdef VEND_AUTOCHANGE_EN
  localparam bit AUTOCHG = 1'b1;
`else
  localparam bit AUTOCHG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] coin_in = '0;
  logic [BW-1:0] button_in = '0;
  logic          cancel_in = 1'b0;
  logic [BW-1:0] beverage_out;
  logic [CW-1:0] change_out;
  logic [CW-1:0] credit_out;
  logic          busy_out;
  logic          error_out;

  int checks = 0;
  int errors = 0;
  int m_credit = 0;
  int prices [4] = '{0, 30, 0, 50};
  int min_price = 0;

  always #5 clk = ~clk;

  vending_fsm_param dut (
    .clk          (clk),
    .rst          (rst),
    .coin_in      (coin_in),
    .button_in    (button_in),
    .cancel_in    (cancel_in),
    .beverage_out (beverage_out),
    .change_out   (change_out),
    .credit_out   (credit_out),
    .busy_out     (busy_out),
    .error_out    (error_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
    coin_in   = '0;
    button_in = '0;
    cancel_in = 1'b0;
  endtask

  // Refund window: change_out holds the model credit for C cycles, then everything clears.
  task automatic expect_refund(input string tag);
    for (int j = 1; j <= C; j++) begin
      checks++;
      if (change_out !== CW'(m_credit) || busy_out !== 1'b1) begin
        errors++;
        $display("FAIL %s refund cyc %0d: change %0d busy %0b, want change %0d busy 1",
                 tag, j, change_out, busy_out, m_credit);
      end
      step();
    end
    m_credit = 0;
    checks++;
    if (change_out !== '0 || credit_out !== '0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL %s refund end: change %0d credit %0d busy %0b, want 0 0 0",
               tag, change_out, credit_out, busy_out);
    end
  endtask

  // One IDLE-cycle request followed by whatever delivery/refund it triggers.
  task automatic run_txn(input int coin, input int btn, input bit can, input int inj, input string tag);
    int price;
    int exp_credit;
    bit exp_err;
    int kind;
    price      = prices[btn];
    exp_credit = m_credit;
    exp_err    = 1'b0;
    kind       = 0;
    if (can && m_credit > 0) begin
      kind = 2;
    end else if (btn != 0) begin
      if (price > 0 && m_credit >= price) begin
        kind       = 1;
        exp_credit = m_credit - price;
        if (coin != 0) begin
          if (m_credit + coin <= CMAX) exp_credit += coin;
          else exp_err = 1'b1;
        end
      end else begin
        exp_err = 1'b1;
      end
    end else if (coin != 0) begin
      if (m_credit + coin <= CMAX) exp_credit = m_credit + coin;
      else exp_err = 1'b1;
    end

    coin_in   = CW'(coin);
    button_in = BW'(btn);
    cancel_in = can;
    step();

    if (kind == 0) begin
      m_credit = exp_credit;
      checks++;
      if (credit_out !== CW'(m_credit) || error_out !== exp_err || busy_out !== 1'b0) begin
        errors++;
        $display("FAIL %s idle: credit %0d err %0b busy %0b, want credit %0d err %0b busy 0",
                 tag, credit_out, error_out, busy_out, m_credit, exp_err);
      end
      step();
      checks++;
      if (error_out !== 1'b0) begin
        errors++;
        $display("FAIL %s err_pulse_len: got %0b want 0", tag, error_out);
      end
    end else if (kind == 1) begin
      m_credit = exp_credit;
      checks++;
      if (error_out !== exp_err) begin
        errors++;
        $display("FAIL %s buy err: got %0b want %0b", tag, error_out, exp_err);
      end
      for (int i = 1; i <= D; i++) begin
        checks++;
        if (beverage_out !== BW'(btn) || busy_out !== 1'b1 || credit_out !== CW'(m_credit)) begin
          errors++;
          $display("FAIL %s deliver cyc %0d: bev %0d busy %0b credit %0d, want bev %0d busy 1 credit %0d",
                   tag, i, beverage_out, busy_out, credit_out, btn, m_credit);
        end
        if (i == inj) begin
          coin_in   = CW'(10);
          button_in = BW'(1);
          cancel_in = 1'b1;
        end
        step();
      end
      checks++;
      if (beverage_out !== '0) begin
        errors++;
        $display("FAIL %s deliver end: bev %0d want 0", tag, beverage_out);
      end
      if (AUTOCHG && m_credit > 0 && m_credit < min_price) begin
        expect_refund(tag);
      end else begin
        checks++;
        if (busy_out !== 1'b0 || credit_out !== CW'(m_credit) || change_out !== '0) begin
          errors++;
          $display("FAIL %s after deliver: busy %0b credit %0d change %0d, want 0 %0d 0",
                   tag, busy_out, credit_out, change_out, m_credit);
        end
      end
    end else begin
      expect_refund(tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (beverage_out !== '0 || change_out !== '0 || credit_out !== '0 || busy_out !== 1'b0 || error_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: bev %0d chg %0d cred %0d busy %0b err %0b, want all 0",
               beverage_out, change_out, credit_out, busy_out, error_out);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    checks++;
    if (credit_out !== '0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: credit %0d busy %0b, want 0 0", credit_out, busy_out);
    end
    m_credit = 0;
  endtask

  task automatic test_coins();
    run_txn(200, 0, 1'b0, 0, "coin200");
    run_txn(20, 0, 1'b0, 0, "coin20");
    run_txn(0, 2, 1'b0, 0, "btn_disabled");
  endtask

  task automatic test_purchases();
    run_txn(0, 3, 1'b0, 0, "buy3a");
    run_txn(0, 3, 1'b0, 0, "buy3b");
    run_txn(0, 1, 1'b0, 0, "buy1a");
    run_txn(0, 1, 1'b0, 0, "buy1b");
    run_txn(0, 1, 1'b0, 0, "buy1c");
    run_txn(0, 1, 1'b0, 0, "buy1d");
    run_txn(0, 1, 1'b0, 0, "buy_no_credit");
  endtask

  task automatic test_autochange();
    run_txn(40, 0, 1'b0, 0, "coin40");
    run_txn(0, 1, 1'b0, 0, "buy_leftover");
    run_txn(0, 0, 1'b0, 0, "idle_hold");
    run_txn(0, 0, 1'b1, 0, "cancel_leftover");
  endtask

  task automatic test_ignore_in_deliver();
    run_txn(200, 0, 1'b0, 0, "coin200b");
    run_txn(0, 3, 1'b0, 3, "buy_inject");
    run_txn(50, 0, 1'b0, 0, "coin50");
    run_txn(900, 0, 1'b0, 0, "coin_over_cap");
    run_txn(0, 0, 1'b1, 0, "cancel200");
  endtask

  task automatic test_cancel();
    run_txn(80, 0, 1'b0, 0, "coin80");
    run_txn(10, 0, 1'b1, 0, "cancel_with_coin");
    run_txn(0, 0, 1'b1, 0, "cancel_zero");
    run_txn(50, 0, 1'b0, 0, "coin50b");
    run_txn(20, 3, 1'b0, 0, "buy_with_coin");
    if (m_credit > 0) run_txn(0, 0, 1'b1, 0, "cancel_rest");
    run_txn(1000, 0, 1'b0, 0, "coin_at_cap");
    run_txn(1, 0, 1'b0, 0, "coin_past_cap");
    run_txn(0, 0, 1'b1, 0, "cancel_cap");
  endtask

  task automatic test_reset_mid();
    run_txn(30, 0, 1'b0, 0, "coin30");
    button_in = BW'(1);
    step();
    repeat (4) step();
    checks++;
    if (beverage_out !== BW'(1) || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_deliver: bev %0d busy %0b, want 1 1", beverage_out, busy_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (beverage_out !== '0 || change_out !== '0 || credit_out !== '0 || busy_out !== 1'b0 || error_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: bev %0d chg %0d cred %0d busy %0b err %0b, want all 0",
               beverage_out, change_out, credit_out, busy_out, error_out);
    end
    #2;
    rst = 1'b1;
    m_credit = 0;
    step();
    step();
    checks++;
    if (busy_out !== 1'b0 || beverage_out !== '0 || credit_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_after: busy %0b bev %0d credit %0d, want 0 0 0",
               busy_out, beverage_out, credit_out);
    end
  endtask

  task automatic test_random();
    int coins [7] = '{5, 10, 25, 50, 100, 500, 900};
    int r;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      run_txn(coins[$urandom_range(0, 6)], 0, 1'b0, 0, "rnd_coin");
      else if (r <= 7) run_txn(0, $urandom_range(1, 3), 1'b0, 0, "rnd_btn");
      else if (r == 8) run_txn(0, 0, 1'b1, 0, "rnd_cancel");
      else             run_txn(coins[$urandom_range(0, 4)], 3, 1'b0, 0, "rnd_coin_btn");
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      if (prices[i] != 0 && (min_price == 0 || prices[i] < min_price)) min_price = prices[i];
    end
    test_reset();
    test_coins();
    test_purchases();
    test_autochange();
    test_ignore_in_deliver();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
